// File: rtl/bus_pkg.sv
// Shared definitions for the command-bus arbiter: opcodes, command-word
// field offsets, command width and the completion-ID rule.
package bus_pkg;

   localparam logic [1:0] OP_INV  = 2'b00;
   localparam logic [1:0] OP_RD   = 2'b01;
   localparam logic [1:0] OP_WR   = 2'b10;
   localparam logic [1:0] OP_HASH = 2'b11;

   localparam logic [1:0] MEM_ID = 2'b00;

   localparam int OP_LSB   = 0;
   localparam int SRC_LSB  = 2;
   localparam int DST_LSB  = 4;
   localparam int FLG_LSB  = 6;
   localparam int ADDR_LSB = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK
   } arb_state_t;

   function automatic int cmdw(input int addrw);
      return addrw + ADDR_LSB;
   endfunction

   // Reads complete from the source; writes and hashes from the destination.
   function automatic logic [1:0] ack_id(input logic [7:0] hdr);
      logic [1:0] id;
      case (hdr[OP_LSB +: 2])
         OP_RD:   id = hdr[SRC_LSB +: 2];
         OP_WR,
         OP_HASH: id = hdr[DST_LSB +: 2];
         default: id = hdr[DST_LSB +: 2];
      endcase
      return id;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr wins,
// reported both one-hot and as an index.
module rr_picker #(
   parameter int N  = 2,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      int j;
      j     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared command bus: grant, capture, issue with
// valid/ready, then hold the bus until the matching ACK or watchdog expiry.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter  int NREQ    = 2,
   parameter  int ADDRW   = 24,
   parameter  int TIMEOUT = 1023,
   localparam int CMDW    = cmdw(ADDRW)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      arb_req,
   input  logic [NREQ*CMDW-1:0] cmd_in,
   output logic [NREQ-1:0]      arb_grant,
   output logic                 bus_valid,
   output logic [CMDW-1:0]      bus_data,
   input  logic                 bus_ready,
   input  logic [2:0]           ack_in,
   output logic                 busy,
   output logic [1:0]           owner,
   output logic                 timeout_err
);

   localparam int WDW = $clog2(TIMEOUT + 1);

   arb_state_t      state_reg, state_next;
   logic [CMDW-1:0] cmd_reg;
   logic [1:0]      owner_reg;
   logic [1:0]      rr_ptr_reg;
   logic            err_reg;
   logic [WDW-1:0]  wdog_reg;

   logic [NREQ-1:0] pick_grant;
   logic [1:0]      pick_idx;
   logic            pick_any;
   logic [CMDW-1:0] win_cmd;
   logic            ack_match;
   logic            wdog_done;
   logic            wdog_expired;

   rr_picker #(.N(NREQ), .IW(2)) u_picker (
      .req   (arb_req),
      .ptr   (rr_ptr_reg),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign win_cmd      = cmd_in[int'(pick_idx)*CMDW +: CMDW];
   assign ack_match    = ack_in[2] && (ack_in[1:0] == ack_id(cmd_reg[7:0]));
   assign wdog_done    = (wdog_reg == WDW'(TIMEOUT));
   // A matching ACK on the final watchdog cycle counts as a normal completion.
   assign wdog_expired = (state_reg == ST_WAIT_ACK) && wdog_done && !ack_match;

   always_comb begin
      state_next = state_reg;
      arb_grant  = '0;
      case (state_reg)
         ST_IDLE: begin
            if (pick_any) begin
               arb_grant = pick_grant;
               if (win_cmd[OP_LSB +: 2] != OP_INV)
                  state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus_ready)
               state_next = ack_match ? ST_IDLE : ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (ack_match || wdog_done)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign bus_valid   = (state_reg == ST_ISSUE);
   assign bus_data    = bus_valid ? cmd_reg : '0;
   assign busy        = (state_reg != ST_IDLE);
   assign owner       = busy ? owner_reg : 2'd0;
   assign timeout_err = err_reg | wdog_expired;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         cmd_reg    <= '0;
         owner_reg  <= '0;
         rr_ptr_reg <= '0;
         err_reg    <= 1'b0;
         wdog_reg   <= '0;
      end else begin
         state_reg <= state_next;
         err_reg   <= 1'b0;
         if (state_reg == ST_IDLE && pick_any) begin
            cmd_reg    <= win_cmd;
            owner_reg  <= pick_idx;
            rr_ptr_reg <= (int'(pick_idx) == NREQ - 1) ? 2'd0 : pick_idx + 2'd1;
            err_reg    <= (win_cmd[OP_LSB +: 2] == OP_INV);
         end
         if (state_reg == ST_ISSUE)
            wdog_reg <= '0;
         else if (state_reg == ST_WAIT_ACK && !wdog_done)
            wdog_reg <= wdog_reg + WDW'(1);
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: scoreboard of issued commands plus
// per-cycle checks of grant, hold, release, watchdog and reset behaviour.
module tb_bus_arbiter;

   localparam int NREQ    = 2;
   localparam int ADDRW   = 24;
   localparam int TIMEOUT = 8;
   localparam int CMDW    = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      arb_req;
   logic [NREQ*CMDW-1:0] cmd_in;
   logic [NREQ-1:0]      arb_grant;
   logic                 bus_valid;
   logic [CMDW-1:0]      bus_data;
   logic                 bus_ready;
   logic [2:0]           ack_in;
   logic                 busy;
   logic [1:0]           owner;
   logic                 timeout_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] cmd;
      logic [1:0]  own;
   } sb_t;
   sb_t sb_q[$];

   // Commands built from fields {addr, flags, dest, src, op}
   localparam logic [31:0] CMD_A = 32'h12345611; // read,  src 00, dest 01
   localparam logic [31:0] CMD_B = 32'hABCDEF26; // write, src 01, dest 10
   localparam logic [31:0] CMD_C = 32'h0001000D; // read,  src 11, dest 00
   localparam logic [31:0] CMD_D = 32'h00020023; // hash,  src 00, dest 10
   localparam logic [31:0] CMD_E = 32'h00ABCD13; // hash,  src 00, dest 01
   localparam logic [31:0] CMD_X = 32'h0FF00054; // invalid opcode

   always #5 clk = ~clk;

   bus_arbiter #(.NREQ(NREQ), .ADDRW(ADDRW), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .arb_req     (arb_req),
      .cmd_in      (cmd_in),
      .arb_grant   (arb_grant),
      .bus_valid   (bus_valid),
      .bus_data    (bus_data),
      .bus_ready   (bus_ready),
      .ack_in      (ack_in),
      .busy        (busy),
      .owner       (owner),
      .timeout_err (timeout_err)
   );

   function automatic logic [1:0] exp_id(input logic [31:0] c);
      return (c[1:0] == 2'b01) ? c[3:2] : c[5:4];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: each accepted bus transfer must match the oldest granted command.
   always @(negedge clk) begin
      sb_t e;
      if (rst === 1'b0 && bus_valid === 1'b1 && bus_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_unexpected observed=%0h expected=none", bus_data);
         end else begin
            e = sb_q.pop_front();
            chk("sb_data", bus_data, e.cmd);
            chk("sb_owner", owner, e.own);
            $display("txn: owner=%0d data=%08h", owner, bus_data);
         end
      end
   end

   // One full transaction: grant, optional stall, accept, optional wait, ACK.
   // wait_n < 0 delivers the ACK in the same cycle as bus_ready.
   task automatic txn(input logic [1:0] req, input int win, input int stall,
                      input int wait_n, input logic [2:0] junk);
      logic [31:0] c;
      logic [1:0]  g;
      c = cmd_in[win*32 +: 32];
      g = 2'b01 << win;
      adv();
      arb_req   = req;
      bus_ready = 1'b0;
      ack_in    = 3'b000;
      @(negedge clk);
      chk("grant", arb_grant, g);
      chk("busy_idle", busy, 0);
      chk("terr_idle", timeout_err, 0);
      sb_q.push_back('{cmd: c, own: 2'(win)});
      repeat (stall) begin
         adv();
         @(negedge clk);
         chk("hold_valid", bus_valid, 1);
         chk("hold_data", bus_data, c);
         chk("hold_nogrant", arb_grant, 0);
      end
      adv();
      bus_ready = 1'b1;
      if (wait_n < 0) ack_in = {1'b1, exp_id(c)};
      @(negedge clk);
      chk("issue_valid", bus_valid, 1);
      chk("issue_owner", owner, 2'(win));
      if (wait_n >= 0) begin
         repeat (wait_n) begin
            adv();
            bus_ready = 1'b0;
            ack_in    = junk;
            @(negedge clk);
            chk("wait_busy", busy, 1);
            chk("wait_valid", bus_valid, 0);
            chk("wait_nogrant", arb_grant, 0);
         end
         adv();
         bus_ready = 1'b0;
         ack_in    = {1'b1, exp_id(c)};
         @(negedge clk);
         chk("ack_busy", busy, 1);
         chk("ack_nogrant", arb_grant, 0);
      end
   endtask

   initial begin
      rst       = 1'b1;
      arb_req   = '0;
      cmd_in    = '0;
      bus_ready = 1'b0;
      ack_in    = 3'b000;
      @(negedge clk);
      chk("rst_grant", arb_grant, 0);
      chk("rst_valid", bus_valid, 0);
      chk("rst_data", bus_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_terr", timeout_err, 0);
      adv();
      rst = 1'b0;

      // Single read, ACK two cycles after issue
      cmd_in = {32'h0, CMD_A};
      txn(2'b01, 0, 0, 1, 3'b000);
      // Lone requester 1 leaves the pointer at 0 for the contention run
      cmd_in = {CMD_B, CMD_A};
      txn(2'b10, 1, 0, 0, 3'b000);

      // Contention: grants alternate 0,1,0,1; last one ACKs with ready
      cmd_in = {CMD_D, CMD_C};
      txn(2'b11, 0, 0, 0, 3'b000);
      txn(2'b11, 1, 0, 1, 3'b000);
      txn(2'b11, 0, 0, 2, 3'b000);
      txn(2'b11, 1, 0, -1, 3'b000);

      // Wrong ACK (id 00) ignored, release on id 01
      cmd_in = {CMD_D, CMD_E};
      txn(2'b01, 0, 0, 1, 3'b100);

      // Backpressure: five stalled cycles with requester 0 also pending
      txn(2'b11, 1, 5, 0, 3'b000);

      // Invalid opcode: grant, no issue, error pulse next cycle
      cmd_in = {CMD_D, CMD_X};
      adv();
      arb_req = 2'b01;
      ack_in  = 3'b000;
      @(negedge clk);
      chk("inv_grant", arb_grant, 2'b01);
      chk("inv_terr0", timeout_err, 0);
      adv();
      arb_req = 2'b00;
      @(negedge clk);
      chk("inv_terr1", timeout_err, 1);
      chk("inv_busy", busy, 0);
      chk("inv_valid", bus_valid, 0);
      txn(2'b11, 1, 0, 0, 3'b000);

      // Watchdog: no matching ACK, release after TIMEOUT counts
      cmd_in = {CMD_D, CMD_A};
      adv();
      arb_req = 2'b11;
      ack_in  = 3'b000;
      @(negedge clk);
      chk("to_grant", arb_grant, 2'b01);
      sb_q.push_back('{cmd: CMD_A, own: 2'd0});
      adv();
      bus_ready = 1'b1;
      @(negedge clk);
      chk("to_issue", bus_valid, 1);
      for (int w = 0; w <= TIMEOUT; w++) begin
         adv();
         bus_ready = 1'b0;
         ack_in    = (w == 3) ? 3'b111 : 3'b000;
         @(negedge clk);
         chk("to_terr", timeout_err, (w == TIMEOUT) ? 1 : 0);
         chk("to_busy", busy, 1);
      end
      adv();
      ack_in = 3'b000;
      @(negedge clk);
      chk("to_next_grant", arb_grant, 2'b10);
      chk("to_terr_clear", timeout_err, 0);
      sb_q.push_back('{cmd: CMD_D, own: 2'd1});
      adv();
      arb_req   = 2'b00;
      bus_ready = 1'b1;
      @(negedge clk);
      chk("pre_rst_valid", bus_valid, 1);
      adv();
      bus_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);

      // Asynchronous reset in WAIT_ACK
      #1 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_owner", owner, 0);
      chk("arst_valid", bus_valid, 0);
      chk("arst_data", bus_data, 0);
      chk("arst_grant", arb_grant, 0);
      chk("arst_terr", timeout_err, 0);
      adv();
      rst     = 1'b0;
      arb_req = 2'b11;
      @(negedge clk);
      chk("post_rst_grant", arb_grant, 2'b01);
      chk("post_rst_busy", busy, 0);
      chk("sb_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule
